// File: rtl/kmkz_div_arbiter_pkg.sv
// Shared definitions for the KMKZ divider front-end: operation codes,
// cache record layout and small decode helpers.
package kmkz_div_arbiter_pkg;

    // Divide/remainder operation codes shared with the issuing pipelines.
    localparam logic [2:0] FUNC_DIV  = 3'b100;
    localparam logic [2:0] FUNC_DIVU = 3'b101;
    localparam logic [2:0] FUNC_REM  = 3'b110;
    localparam logic [2:0] FUNC_REMU = 3'b111;

    localparam logic [31:0] INT_MIN = 32'h8000_0000;
    localparam logic [31:0] ALL_ONE = 32'hFFFF_FFFF;

    // Last divider result, reused when the same operands come back.
    typedef struct packed {
        logic        valid;
        logic        sgn;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] q;
        logic [31:0] r;
    } div_cache_t;

    function automatic logic func_is_signed(input logic [2:0] fun);
        return (fun == FUNC_DIV) || (fun == FUNC_REM);
    endfunction

    function automatic logic func_is_rem(input logic [2:0] fun);
        return (fun == FUNC_REM) || (fun == FUNC_REMU);
    endfunction

endpackage

// File: rtl/kmkz_rr_arbiter2.sv
// Two-way round-robin arbiter. The pointer names the requester that wins a
// tie; after every accepted grant it moves to the requester that lost.
module kmkz_rr_arbiter2
    import kmkz_div_arbiter_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] grant_o
);

    logic ptr_q;
    logic ptr_d;

    // Grant selection and pointer update.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        grant_o = 2'b00;
        if (!ptr_q) begin
            if (req_i[0])      grant_o = 2'b01;
            else if (req_i[1]) grant_o = 2'b10;
        end else begin
            if (req_i[1])      grant_o = 2'b10;
            else if (req_i[0]) grant_o = 2'b01;
        end
        ptr_d = ptr_q;
        if (advance_i && (grant_o != 2'b00)) begin
            ptr_d = grant_o[0];
        end
    end

    // Pointer register, requester 0 favoured out of reset.
    always_ff @(posedge clk_i) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) ptr_q <= 1'b0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/kmkz_div_arbiter.sv
// Shares one iterative divider between two requesters. Trivial cases
// (zero divisor, signed overflow, repeat of the last operands) are answered
// locally without starting the divider.
module kmkz_div_arbiter
    import kmkz_div_arbiter_pkg::*;
#(
    parameter bit CACHE_EN = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic [2:0]  req0_fun_i,
    input  logic [31:0] req0_rs1_i,
    input  logic [31:0] req0_rs2_i,
    input  logic        req0_kill_i,
    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic [2:0]  req1_fun_i,
    input  logic [31:0] req1_rs1_i,
    input  logic [31:0] req1_rs2_i,
    input  logic        req1_kill_i,
    output logic        resp0_valid_o,
    output logic [31:0] resp0_data_o,
    input  logic        resp0_ready_i,
    output logic        resp1_valid_o,
    output logic [31:0] resp1_data_o,
    input  logic        resp1_ready_i,
    output logic        div_start_o,
    output logic        div_signed_o,
    output logic [31:0] div_rs1_o,
    output logic [31:0] div_rs2_o,
    input  logic        div_done_i,
    input  logic [31:0] div_q_i,
    input  logic [31:0] div_r_i
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic [2:0]  fun_q, fun_d;
    logic [31:0] rs1_q, rs1_d;
    logic [31:0] rs2_q, rs2_d;
    logic        killed_q, killed_d;
    div_cache_t  cache_q, cache_d;
    logic        div_start_q, div_start_d;
    logic        div_signed_q, div_signed_d;
    logic [31:0] div_rs1_q, div_rs1_d;
    logic [31:0] div_rs2_q, div_rs2_d;
    logic [1:0]  resp_valid_q, resp_valid_d;
    logic [31:0] resp_data_q, resp_data_d;

    logic        idle;
    logic [1:0]  arb_req;
    logic [1:0]  grant;
    logic        advance;
    logic        own_kill;
    logic        own_resp_ready;
    logic        cache_hit;
    logic        load_resp;
    logic [31:0] res_q;
    logic [31:0] res_r;

    assign idle           = (state_q == S_IDLE);
    // A requester asserting kill cannot be accepted in the same cycle.
    assign arb_req        = {req1_valid_i && !req1_kill_i, req0_valid_i && !req0_kill_i};
    assign own_kill       = owner_q ? req1_kill_i : req0_kill_i;
    assign own_resp_ready = owner_q ? resp1_ready_i : resp0_ready_i;
    assign cache_hit      = CACHE_EN && cache_q.valid && (cache_q.rs1 == rs1_q) &&
                            (cache_q.rs2 == rs2_q) && (cache_q.sgn == func_is_signed(fun_q));

    kmkz_rr_arbiter2 u_rr (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (arb_req),
        .advance_i (advance),
        .grant_o   (grant)
    );

    assign req0_ready_o  = idle && !rst_i && grant[0];
    assign req1_ready_o  = idle && !rst_i && grant[1];
    assign resp0_valid_o = resp_valid_q[0];
    assign resp1_valid_o = resp_valid_q[1];
    assign resp0_data_o  = resp_valid_q[0] ? resp_data_q : 32'h0;
    assign resp1_data_o  = resp_valid_q[1] ? resp_data_q : 32'h0;
    // A kill arriving while the start pulse is up cancels the pulse.
    assign div_start_o   = div_start_q && !own_kill;
    assign div_signed_o  = div_signed_q;
    assign div_rs1_o     = div_rs1_q;
    assign div_rs2_o     = div_rs2_q;

    // Next-state and next-output computation for the request sequencer.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        fun_d        = fun_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        killed_d     = killed_q;
        cache_d      = cache_q;
        div_start_d  = 1'b0;
        div_signed_d = div_signed_q;
        div_rs1_d    = div_rs1_q;
        div_rs2_d    = div_rs2_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        advance      = 1'b0;
        load_resp    = 1'b0;
        res_q        = 32'h0;
        res_r        = 32'h0;

        unique case (state_q)
            S_IDLE: begin
                if (grant != 2'b00) begin
                    advance  = 1'b1;
                    owner_d  = grant[1];
                    fun_d    = grant[1] ? req1_fun_i : req0_fun_i;
                    rs1_d    = grant[1] ? req1_rs1_i : req0_rs1_i;
                    rs2_d    = grant[1] ? req1_rs2_i : req0_rs2_i;
                    killed_d = 1'b0;
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                if (own_kill) begin
                    state_d = S_IDLE;
                end else if (rs2_q == 32'h0) begin
                    load_resp = 1'b1;
                    res_q     = ALL_ONE;
                    res_r     = rs1_q;
                end else if (func_is_signed(fun_q) && (rs1_q == INT_MIN) && (rs2_q == ALL_ONE)) begin
                    load_resp = 1'b1;
                    res_q     = INT_MIN;
                    res_r     = 32'h0;
                end else if (cache_hit) begin
                    load_resp = 1'b1;
                    res_q     = cache_q.q;
                    res_r     = cache_q.r;
                end else begin
                    div_start_d  = 1'b1;
                    div_signed_d = func_is_signed(fun_q);
                    div_rs1_d    = rs1_q;
                    div_rs2_d    = rs2_q;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = own_kill ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (own_kill) killed_d = 1'b1;
                if (div_done_i) begin
                    cache_d.valid = 1'b1;
                    cache_d.sgn   = div_signed_q;
                    cache_d.rs1   = div_rs1_q;
                    cache_d.rs2   = div_rs2_q;
                    cache_d.q     = div_q_i;
                    cache_d.r     = div_r_i;
                    if (killed_q || own_kill) begin
                        state_d = S_IDLE;
                    end else begin
                        load_resp = 1'b1;
                        res_q     = div_q_i;
                        res_r     = div_r_i;
                    end
                end
            end
            S_RESP: begin
                if (own_kill || own_resp_ready) begin
                    resp_valid_d = 2'b00;
                    resp_data_d  = 32'h0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load_resp) begin
            state_d               = S_RESP;
            resp_valid_d          = 2'b00;
            resp_valid_d[owner_q] = 1'b1;
            resp_data_d           = func_is_rem(fun_q) ? res_r : res_q;
        end
    end

    // Sequencer, operand, cache and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            fun_q        <= 3'b000;
            rs1_q        <= 32'h0;
            rs2_q        <= 32'h0;
            killed_q     <= 1'b0;
            cache_q      <= '0;
            div_start_q  <= 1'b0;
            div_signed_q <= 1'b0;
            div_rs1_q    <= 32'h0;
            div_rs2_q    <= 32'h0;
            resp_valid_q <= 2'b00;
            resp_data_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            fun_q        <= fun_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            killed_q     <= killed_d;
            cache_q      <= cache_d;
            div_start_q  <= div_start_d;
            div_signed_q <= div_signed_d;
            div_rs1_q    <= div_rs1_d;
            div_rs2_q    <= div_rs2_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

endmodule

// File: tb/tb_kmkz_div_arbiter.sv
// Directed bench for kmkz_div_arbiter with hand-computed expectations.
module tb_kmkz_div_arbiter;

    localparam logic [2:0] F_DIV  = 3'b100;
    localparam logic [2:0] F_DIVU = 3'b101;
    localparam logic [2:0] F_REM  = 3'b110;
    localparam logic [2:0] F_REMU = 3'b111;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req0_valid_i, req0_ready_o, req0_kill_i;
    logic [2:0]  req0_fun_i;
    logic [31:0] req0_rs1_i, req0_rs2_i;
    logic        req1_valid_i, req1_ready_o, req1_kill_i;
    logic [2:0]  req1_fun_i;
    logic [31:0] req1_rs1_i, req1_rs2_i;
    logic        resp0_valid_o, resp0_ready_i;
    logic [31:0] resp0_data_o;
    logic        resp1_valid_o, resp1_ready_i;
    logic [31:0] resp1_data_o;
    logic        div_start_o, div_signed_o, div_done_i;
    logic [31:0] div_rs1_o, div_rs2_o, div_q_i, div_r_i;

    int total = 0;
    int bad   = 0;
    int start_cnt = 0;

    kmkz_div_arbiter #(.CACHE_EN(1'b1)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_fun_i(req0_fun_i),
        .req0_rs1_i(req0_rs1_i), .req0_rs2_i(req0_rs2_i), .req0_kill_i(req0_kill_i),
        .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_fun_i(req1_fun_i),
        .req1_rs1_i(req1_rs1_i), .req1_rs2_i(req1_rs2_i), .req1_kill_i(req1_kill_i),
        .resp0_valid_o(resp0_valid_o), .resp0_data_o(resp0_data_o), .resp0_ready_i(resp0_ready_i),
        .resp1_valid_o(resp1_valid_o), .resp1_data_o(resp1_data_o), .resp1_ready_i(resp1_ready_i),
        .div_start_o(div_start_o), .div_signed_o(div_signed_o), .div_rs1_o(div_rs1_o),
        .div_rs2_o(div_rs2_o), .div_done_i(div_done_i), .div_q_i(div_q_i), .div_r_i(div_r_i)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) if (div_start_o === 1'b1) start_cnt <= start_cnt + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_req(input int n, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (n == 0) begin
            req0_valid_i = 1'b1; req0_fun_i = f; req0_rs1_i = a; req0_rs2_i = b;
        end else begin
            req1_valid_i = 1'b1; req1_fun_i = f; req1_rs1_i = a; req1_rs2_i = b;
        end
    endtask

    // Holds valid until ready is seen (bounded), lets the accept edge pass,
    // then drops valid. Returns in the cycle after the accept.
    task automatic wait_accept(input int n, output bit ok);
        ok = 1'b0;
        #1;
        for (int i = 0; i < 20; i++) begin
            if ((n == 0 && req0_ready_o === 1'b1) || (n == 1 && req1_ready_o === 1'b1)) begin
                ok = 1'b1;
                break;
            end
            step();
            #1;
        end
        step();
        if (n == 0) req0_valid_i = 1'b0;
        else        req1_valid_i = 1'b0;
    endtask

    task automatic finish_resp(input int n);
        if (n == 0) resp0_ready_i = 1'b1;
        else        resp1_ready_i = 1'b1;
        step();
        resp0_ready_i = 1'b0;
        resp1_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        step();
        step();
        total++; if (req0_ready_o !== 1'b0 || req1_ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b%b exp=00", req1_ready_o, req0_ready_o); end
        total++; if (resp0_valid_o !== 1'b0 || resp1_valid_o !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b%b exp=00", resp1_valid_o, resp0_valid_o); end
        total++; if (div_start_o !== 1'b0 || div_signed_o !== 1'b0) begin bad++; $display("FAIL reset_div_ctl got=%b%b exp=00", div_start_o, div_signed_o); end
        total++; if (div_rs1_o !== 32'h0 || div_rs2_o !== 32'h0 || resp0_data_o !== 32'h0) begin bad++; $display("FAIL reset_data got=%h/%h/%h exp=0", div_rs1_o, div_rs2_o, resp0_data_o); end
        rst_i = 1'b0;
        step();
    endtask

    task automatic test_divider_path();
        bit ok;
        int s0;
        s0 = start_cnt;
        set_req(0, F_DIVU, 32'd100, 32'd7);
        wait_accept(0, ok);
        total++; if (!ok) begin bad++; $display("FAIL div_accept got=no_ready exp=ready"); end
        total++; if (div_start_o !== 1'b0) begin bad++; $display("FAIL div_start_early got=%b exp=0", div_start_o); end
        step();
        total++; if (div_start_o !== 1'b1 || div_rs1_o !== 32'd100 || div_rs2_o !== 32'd7 || div_signed_o !== 1'b0)
            begin bad++; $display("FAIL div_issue got=%b %0d %0d %b exp=1 100 7 0", div_start_o, div_rs1_o, div_rs2_o, div_signed_o); end
        step();
        total++; if (div_start_o !== 1'b0 || resp0_valid_o !== 1'b0) begin bad++; $display("FAIL div_wait got=start%b resp%b exp=0 0", div_start_o, resp0_valid_o); end
        step();
        div_done_i = 1'b1; div_q_i = 32'd14; div_r_i = 32'd2;
        step();
        div_done_i = 1'b0;
        total++; if (resp0_valid_o !== 1'b1 || resp0_data_o !== 32'd14 || resp1_valid_o !== 1'b0)
            begin bad++; $display("FAIL div_resp got=%b %0d %b exp=1 14 0", resp0_valid_o, resp0_data_o, resp1_valid_o); end
        step();
        total++; if (resp0_valid_o !== 1'b1 || resp0_data_o !== 32'd14) begin bad++; $display("FAIL div_resp_hold got=%b %0d exp=1 14", resp0_valid_o, resp0_data_o); end
        finish_resp(0);
        total++; if (resp0_valid_o !== 1'b0) begin bad++; $display("FAIL div_resp_drop got=%b exp=0", resp0_valid_o); end
        total++; if (start_cnt !== s0 + 1) begin bad++; $display("FAIL div_start_count got=%0d exp=%0d", start_cnt, s0 + 1); end
    endtask

    task automatic test_cache_hit();
        bit ok;
        int s0;
        s0 = start_cnt;
        set_req(1, F_REMU, 32'd100, 32'd7);
        wait_accept(1, ok);
        total++; if (!ok) begin bad++; $display("FAIL hit_accept got=no_ready exp=ready"); end
        step();
        total++; if (resp1_valid_o !== 1'b1 || resp1_data_o !== 32'd2 || resp0_valid_o !== 1'b0)
            begin bad++; $display("FAIL hit_resp got=%b %0d %b exp=1 2 0", resp1_valid_o, resp1_data_o, resp0_valid_o); end
        finish_resp(1);
        total++; if (start_cnt !== s0) begin bad++; $display("FAIL hit_no_start got=%0d exp=%0d", start_cnt, s0); end
    endtask

    task automatic test_special();
        bit ok;
        int s0;
        s0 = start_cnt;
        set_req(0, F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_accept(0, ok);
        step();
        total++; if (!ok || resp0_data_o !== 32'h8000_0000 || resp0_valid_o !== 1'b1)
            begin bad++; $display("FAIL ovf_div got=%b %h exp=1 80000000", resp0_valid_o, resp0_data_o); end
        finish_resp(0);
        set_req(0, F_REM, 32'd5, 32'd0);
        wait_accept(0, ok);
        step();
        total++; if (!ok || resp0_data_o !== 32'd5 || resp0_valid_o !== 1'b1)
            begin bad++; $display("FAIL zero_rem got=%b %0d exp=1 5", resp0_valid_o, resp0_data_o); end
        finish_resp(0);
        set_req(0, F_DIVU, 32'd9, 32'd0);
        wait_accept(0, ok);
        step();
        total++; if (!ok || resp0_data_o !== 32'hFFFF_FFFF) begin bad++; $display("FAIL zero_divu got=%h exp=ffffffff", resp0_data_o); end
        finish_resp(0);
        total++; if (start_cnt !== s0) begin bad++; $display("FAIL special_no_start got=%0d exp=%0d", start_cnt, s0); end
        // Unsigned with the overflow pattern is an ordinary division.
        set_req(0, F_DIVU, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_accept(0, ok);
        step();
        total++; if (!ok || div_start_o !== 1'b1 || div_signed_o !== 1'b0)
            begin bad++; $display("FAIL unsigned_no_ovf got=%b %b exp=1 0", div_start_o, div_signed_o); end
        step();
        div_done_i = 1'b1; div_q_i = 32'd0; div_r_i = 32'h8000_0000;
        step();
        div_done_i = 1'b0;
        total++; if (resp0_valid_o !== 1'b1 || resp0_data_o !== 32'd0) begin bad++; $display("FAIL unsigned_no_ovf_resp got=%b %h exp=1 0", resp0_valid_o, resp0_data_o); end
        finish_resp(0);
    endtask

    task automatic test_back_to_back();
        bit ok;
        rst_i = 1'b1; step(); rst_i = 1'b0; step();
        set_req(0, F_DIVU, 32'd7, 32'd0);
        set_req(1, F_REMU, 32'd9, 32'd0);
        #1;
        total++; if (req0_ready_o !== 1'b1 || req1_ready_o !== 1'b0) begin bad++; $display("FAIL rr_first got=%b%b exp=01", req1_ready_o, req0_ready_o); end
        step();
        req0_valid_i = 1'b0;
        step();
        total++; if (resp0_valid_o !== 1'b1 || resp0_data_o !== 32'hFFFF_FFFF || req1_ready_o !== 1'b0)
            begin bad++; $display("FAIL rr_resp0 got=%b %h rdy1=%b exp=1 ffffffff 0", resp0_valid_o, resp0_data_o, req1_ready_o); end
        finish_resp(0);
        #1;
        total++; if (req1_ready_o !== 1'b1) begin bad++; $display("FAIL rr_second got=%b exp=1", req1_ready_o); end
        step();
        req1_valid_i = 1'b0;
        step();
        total++; if (resp1_valid_o !== 1'b1 || resp1_data_o !== 32'd9) begin bad++; $display("FAIL rr_resp1 got=%b %0d exp=1 9", resp1_valid_o, resp1_data_o); end
        finish_resp(1);
        // A lone requester-0 accept moves the pointer to requester 1.
        set_req(0, F_REMU, 32'd9, 32'd0);
        wait_accept(0, ok);
        step();
        finish_resp(0);
        set_req(0, F_DIVU, 32'd7, 32'd0);
        set_req(1, F_REMU, 32'd9, 32'd0);
        #1;
        total++; if (!ok || req1_ready_o !== 1'b1 || req0_ready_o !== 1'b0) begin bad++; $display("FAIL rr_alternate got=%b%b exp=10", req1_ready_o, req0_ready_o); end
        step();
        req1_valid_i = 1'b0;
        step();
        finish_resp(1);
        wait_accept(0, ok);
        step();
        total++; if (!ok || resp0_valid_o !== 1'b1) begin bad++; $display("FAIL rr_drain got=%b exp=1", resp0_valid_o); end
        finish_resp(0);
    endtask

    task automatic test_kill_check();
        bit ok;
        int s0;
        s0 = start_cnt;
        set_req(1, F_DIVU, 32'd50, 32'd6);
        wait_accept(1, ok);
        req1_kill_i = 1'b1;
        step();
        req1_kill_i = 1'b0;
        step();
        total++; if (!ok || resp1_valid_o !== 1'b0 || start_cnt !== s0)
            begin bad++; $display("FAIL kill_check got=resp%b starts=%0d exp=0 %0d", resp1_valid_o, start_cnt, s0); end
        set_req(1, F_DIVU, 32'd50, 32'd6);
        wait_accept(1, ok);
        step();
        req1_kill_i = 1'b1;
        #1;
        total++; if (!ok || div_start_o !== 1'b0) begin bad++; $display("FAIL kill_issue got=%b exp=0", div_start_o); end
        step();
        req1_kill_i = 1'b0;
        step();
        total++; if (start_cnt !== s0 || resp1_valid_o !== 1'b0) begin bad++; $display("FAIL kill_issue_after got=%0d %b exp=%0d 0", start_cnt, resp1_valid_o, s0); end
        set_req(0, F_REMU, 32'd9, 32'd0);
        req0_kill_i = 1'b1;
        #1;
        total++; if (req0_ready_o !== 1'b0) begin bad++; $display("FAIL kill_idle got=%b exp=0", req0_ready_o); end
        req0_kill_i = 1'b0;
        wait_accept(0, ok);
        step();
        total++; if (!ok || resp0_data_o !== 32'd9) begin bad++; $display("FAIL kill_idle_after got=%0d exp=9", resp0_data_o); end
        finish_resp(0);
    endtask

    task automatic test_kill_wait();
        bit ok;
        int s0;
        s0 = start_cnt;
        set_req(0, F_DIVU, 32'd200, 32'd3);
        wait_accept(0, ok);
        step();
        total++; if (!ok || div_start_o !== 1'b1) begin bad++; $display("FAIL killw_start got=%b exp=1", div_start_o); end
        step();
        req0_kill_i = 1'b1;
        step();
        req0_kill_i = 1'b0;
        step();
        div_done_i = 1'b1; div_q_i = 32'd66; div_r_i = 32'd2;
        step();
        div_done_i = 1'b0;
        total++; if (resp0_valid_o !== 1'b0) begin bad++; $display("FAIL killw_no_resp got=%b exp=0", resp0_valid_o); end
        step();
        total++; if (resp0_valid_o !== 1'b0) begin bad++; $display("FAIL killw_no_resp_late got=%b exp=0", resp0_valid_o); end
        // The abandoned result still refreshed the cache.
        set_req(0, F_DIVU, 32'd200, 32'd3);
        wait_accept(0, ok);
        step();
        total++; if (!ok || resp0_valid_o !== 1'b1 || resp0_data_o !== 32'd66 || start_cnt !== s0 + 1)
            begin bad++; $display("FAIL killw_next got=%b %0d starts=%0d exp=1 66 %0d", resp0_valid_o, resp0_data_o, start_cnt, s0 + 1); end
        finish_resp(0);
    endtask

    task automatic test_reset_wait();
        bit ok;
        set_req(0, F_DIV, 32'd77, 32'd5);
        wait_accept(0, ok);
        step();
        total++; if (!ok || div_signed_o !== 1'b1 || div_start_o !== 1'b1) begin bad++; $display("FAIL rstw_issue got=%b %b exp=1 1", div_start_o, div_signed_o); end
        step();
        rst_i = 1'b1;
        step();
        total++; if ({req0_ready_o, req1_ready_o, resp0_valid_o, resp1_valid_o, div_start_o, div_signed_o} !== 6'b0 ||
                     div_rs1_o !== 32'h0 || div_rs2_o !== 32'h0 || resp0_data_o !== 32'h0 || resp1_data_o !== 32'h0)
            begin bad++; $display("FAIL rstw_outputs got=%b%b%b%b%b%b %h %h exp=0", req0_ready_o, req1_ready_o, resp0_valid_o, resp1_valid_o, div_start_o, div_signed_o, div_rs1_o, div_rs2_o); end
        rst_i = 1'b0;
        div_done_i = 1'b1; div_q_i = 32'd15; div_r_i = 32'd2;
        step();
        div_done_i = 1'b0;
        step();
        total++; if (resp0_valid_o !== 1'b0 || resp1_valid_o !== 1'b0) begin bad++; $display("FAIL rstw_stale_done got=%b%b exp=00", resp1_valid_o, resp0_valid_o); end
        // Cache was invalidated, so a repeat of earlier operands goes to the divider.
        set_req(0, F_DIVU, 32'd100, 32'd7);
        wait_accept(0, ok);
        step();
        total++; if (!ok || div_start_o !== 1'b1) begin bad++; $display("FAIL rstw_cache_cleared got=%b exp=1", div_start_o); end
        step();
        div_done_i = 1'b1; div_q_i = 32'd14; div_r_i = 32'd2;
        step();
        div_done_i = 1'b0;
        total++; if (resp0_valid_o !== 1'b1 || resp0_data_o !== 32'd14) begin bad++; $display("FAIL rstw_after got=%b %0d exp=1 14", resp0_valid_o, resp0_data_o); end
        finish_resp(0);
    endtask

    initial begin
        rst_i = 1'b1;
        req0_valid_i = 1'b0; req0_fun_i = 3'b0; req0_rs1_i = 32'h0; req0_rs2_i = 32'h0; req0_kill_i = 1'b0;
        req1_valid_i = 1'b0; req1_fun_i = 3'b0; req1_rs1_i = 32'h0; req1_rs2_i = 32'h0; req1_kill_i = 1'b0;
        resp0_ready_i = 1'b0; resp1_ready_i = 1'b0;
        div_done_i = 1'b0; div_q_i = 32'h0; div_r_i = 32'h0;
        test_reset();
        test_divider_path();
        test_cache_hit();
        test_special();
        test_back_to_back();
        test_kill_check();
        test_kill_wait();
        test_reset_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
